// File: rtl/spi_arb_pkg.sv
// Shared state encoding and widths for the SPI transaction arbiter.
package spi_arb_pkg;

    localparam int BYTE_W   = 8;
    localparam int PH_CNT_W = 8;   // CS setup/hold phase counter
    localparam int TO_CNT_W = 16;  // WAIT timeout counter

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RELEASE = 3'd5
    } state_e;

    // One-hot select for up to eight requesters.
    function automatic logic [7:0] idx_to_sel(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin chooser: first active request after ptr_i, wrapping.
module spi_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Walk from the farthest candidate to the nearest so the nearest hit wins.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one byte-wide SPI master among N_REQ round-robin requesters.
// Define SPI_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles with an err pulse.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [BYTE_W*N_REQ-1:0] tx_data,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic [BYTE_W-1:0]       rx_data,
    output logic [N_REQ-1:0]        cs_n,
    output logic                    m_start,
    output logic [BYTE_W-1:0]       m_tx,
    input  logic                    m_busy,
    input  logic                    m_done,
    input  logic [BYTE_W-1:0]       m_rx
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [PH_CNT_W-1:0] SETUP_LAST = PH_CNT_W'(CS_SETUP - 1);
    localparam logic [PH_CNT_W-1:0] HOLD_LAST  = PH_CNT_W'(CS_HOLD - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    win_q;
    logic [PH_CNT_W-1:0] ph_cnt_q;
    logic [N_REQ-1:0]    cs_n_q;
    logic [N_REQ-1:0]    ack_q;
    logic                m_start_q;
    logic [BYTE_W-1:0]   m_tx_q;
    logic [BYTE_W-1:0]   rx_data_q;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [N_REQ-1:0]    pick_sel_d;
    logic [N_REQ-1:0]    win_sel_d;

    spi_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pick_sel_d = N_REQ'(idx_to_sel(3'(pick_idx)));
    assign win_sel_d  = N_REQ'(idx_to_sel(3'(win_q)));

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);
    logic [TO_CNT_W-1:0] to_cnt_q;
    logic [N_REQ-1:0]    err_q;
    assign err = err_q;
`else
    assign err = '0;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            win_q     <= '0;
            ph_cnt_q  <= '0;
            cs_n_q    <= '1;
            ack_q     <= '0;
            m_start_q <= 1'b0;
            m_tx_q    <= '0;
            rx_data_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle, so they can never stretch past one.
            ack_q     <= '0;
            m_start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q     <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        win_q    <= pick_idx;
                        m_tx_q   <= tx_data[pick_idx*BYTE_W +: BYTE_W];
                        cs_n_q   <= ~pick_sel_d;
                        ph_cnt_q <= '0;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (ph_cnt_q == SETUP_LAST) state_q  <= ST_START;
                    else                        ph_cnt_q <= ph_cnt_q + PH_CNT_W'(1);
                end
                ST_START: begin
                    if (!m_busy) begin
                        m_start_q <= 1'b1;
                        state_q   <= ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (m_done) begin
                        rx_data_q <= m_rx;
                        ph_cnt_q  <= '0;
                        state_q   <= ST_HOLD;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    // Abandoned transfer skips HOLD and reports err instead of ack.
                    else if (to_cnt_q == TO_LAST) begin
                        rx_data_q <= '0;
                        err_q     <= win_sel_d;
                        cs_n_q    <= '1;
                        state_q   <= ST_RELEASE;
                    end else begin
                        to_cnt_q  <= to_cnt_q + TO_CNT_W'(1);
                    end
`endif
                end
                ST_HOLD: begin
                    if (ph_cnt_q == HOLD_LAST) begin
                        ack_q   <= win_sel_d;
                        cs_n_q  <= '1;
                        state_q <= ST_RELEASE;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PH_CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    ptr_q   <= win_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack     = ack_q;
    assign cs_n    = cs_n_q;
    assign m_start = m_start_q;
    assign m_tx    = m_tx_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: edge-timestamp transaction model plus directed tests.
module tb_spi_txn_arbiter;

    localparam int N_REQ    = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 1;
    localparam int TIMEOUT  = 16;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int SEL_START = 0;
    localparam int SEL_ACK   = 1;
    localparam int SEL_ERR   = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] tx_data;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [7:0]  rx_data;
    logic [3:0]  cs_n;
    logic        m_start;
    logic [7:0]  m_tx;
    logic        m_busy;
    logic        m_done;
    logic [7:0]  m_rx;

    int checks = 0;
    int errors = 0;

    spi_txn_arbiter #(
        .N_REQ    (N_REQ),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .tx_data (tx_data),
        .ack     (ack),
        .err     (err),
        .rx_data (rx_data),
        .cs_n    (cs_n),
        .m_start (m_start),
        .m_tx    (m_tx),
        .m_busy  (m_busy),
        .m_done  (m_done),
        .m_rx    (m_rx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sel_idx(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic int rr_winner(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // ---------------- reference model: timestamps per transaction ----------------
    int         n_edge  = 0;
    bit         model_ok = 1'b0;
    bit         t_active = 1'b0;
    int         free_at = 0;
    int         ptr_m   = 3;
    int         win_m   = 0;
    int         grant_e = 0;
    int         start_e = -1;
    int         rel_e   = -1;
    logic [3:0] e_cs_n  = 4'hF;
    logic [3:0] e_ack   = 4'h0;
    logic [3:0] e_err   = 4'h0;
    logic [7:0] e_rx    = 8'h00;
    logic [7:0] e_mtx   = 8'h00;
    logic       e_mstart = 1'b0;

    always @(posedge clk) begin
        n_edge++;
        e_ack    = 4'h0;
        e_err    = 4'h0;
        e_mstart = 1'b0;
        if (rst) begin
            model_ok = 1'b1;
            t_active = 1'b0;
            free_at  = n_edge + 1;
            ptr_m    = 3;
            e_cs_n   = 4'hF;
            e_rx     = 8'h00;
            e_mtx    = 8'h00;
        end else if (!t_active) begin
            if (n_edge >= free_at && req != 4'h0) begin
                win_m    = rr_winner(req, ptr_m);
                t_active = 1'b1;
                grant_e  = n_edge;
                start_e  = -1;
                rel_e    = -1;
                e_cs_n   = ~(4'b0001 << win_m);
                e_mtx    = tx_data[win_m*8 +: 8];
            end
        end else if (start_e < 0) begin
            if (n_edge >= grant_e + 1 + CS_SETUP && !m_busy) begin
                start_e  = n_edge;
                e_mstart = 1'b1;
            end
        end else if (rel_e < 0) begin
            if (m_done) begin
                e_rx  = m_rx;
                rel_e = n_edge + CS_HOLD;
            end else if (TO_EN && n_edge == start_e + TIMEOUT) begin
                e_rx     = 8'h00;
                e_err    = 4'b0001 << win_m;
                e_cs_n   = 4'hF;
                t_active = 1'b0;
                ptr_m    = win_m;
                free_at  = n_edge + 2;
            end
        end else if (n_edge == rel_e) begin
            e_ack    = 4'b0001 << win_m;
            e_cs_n   = 4'hF;
            t_active = 1'b0;
            ptr_m    = win_m;
            free_at  = n_edge + 2;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [3:0] prev_ack = 4'h0;
    always @(negedge clk) begin
        if (model_ok) begin
            check("cs_n",    32'(cs_n),    32'(e_cs_n));
            check("ack",     32'(ack),     32'(e_ack));
            check("err",     32'(err),     32'(e_err));
            check("m_start", 32'(m_start), 32'(e_mstart));
            check("m_tx",    32'(m_tx),    32'(e_mtx));
            check("rx_data", 32'(rx_data), 32'(e_rx));
            check("cs_n_at_most_one_low", 32'($countones(~cs_n) <= 1), 32'd1);
            check("ack_err_exclusive",    32'(ack != 4'h0 && err != 4'h0), 32'd0);
            check("ack_single_cycle",     32'(ack != 4'h0 && prev_ack != 4'h0), 32'd0);
            prev_ack = ack;
        end
    end

    // ---------------- behavioural SPI master ----------------
    bit         master_en  = 1'b1;
    int         master_lat = 3;
    logic [7:0] rx_key     = 8'h00;
    int         stray_req  = 0;
    int         stray_ack  = 0;
    int         master_cnt = 0;

    initial begin
        m_done = 1'b0;
        m_rx   = 8'h00;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (master_cnt > 0) begin
                master_cnt--;
                if (master_cnt == 0) begin
                    m_done = 1'b1;
                    m_rx   = m_tx ^ rx_key;
                end
            end else if (stray_req != stray_ack) begin
                stray_ack++;
                m_done = 1'b1;
                m_rx   = 8'hEE;
            end
            if (m_start && master_en) master_cnt = master_lat;
        end
    end

    task automatic wait_sig(input string name, input int sel, input int budget, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            @(negedge clk);
            cyc++;
            case (sel)
                SEL_START: hit = m_start;
                SEL_ACK:   hit = (ack != 4'h0);
                default:   hit = (err != 4'h0);
            endcase
        end
        check({name, "_bound"}, 32'(hit), 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int cyc;
        int acks;
        int gap;
        int min_gap;
        bit seen_low;
        int order[5];
        logic [7:0] rxs[5];
        int first_start;
        int n_start;
        int ack_k;
        logic [3:0] ack_v;
        logic [7:0] ack_rx;
        logic [7:0] start_tx;

        rst = 1'b1; req = 4'h0; tx_data = 32'h0; m_busy = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        check("reset_cs_n",    32'(cs_n),    32'hF);
        check("reset_ack",     32'(ack),     32'h0);
        check("reset_m_start", 32'(m_start), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_m_tx",    32'(m_tx),    32'h00);

        // Single transaction
        rst = 1'b0;
        req = 4'b0001;
        tx_data[7:0] = 8'h53;
        rx_key = 8'h53 ^ 8'hA5;
        @(negedge clk);
        check("single_cs_n", 32'(cs_n), 32'hE);
        wait_sig("single_start", SEL_START, 20, cyc);
        check("single_start_latency", 32'(cyc), 32'd3);
        check("single_m_tx", 32'(m_tx), 32'h53);
        wait_sig("single_ack", SEL_ACK, 50, cyc);
        check("single_ack_val", 32'(ack), 32'h1);
        check("single_rx", 32'(rx_data), 32'hA5);
        req = 4'h0;

        // Stray m_done while idle must be ignored
        repeat (3) @(negedge clk);
        stray_req++;
        repeat (3) @(negedge clk);
        check("stray_done_rx", 32'(rx_data), 32'hA5);

        // Contention from reset: order 0,1,2,3,0
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req = 4'hF;
        tx_data = 32'h44332211;
        rx_key = 8'h0F;
        master_lat = 2;
        acks = 0; gap = 0; min_gap = 99; seen_low = 1'b0;
        for (int i = 0; i < 5; i++) begin order[i] = -1; rxs[i] = 8'h00; end
        for (int c = 0; c < 300 && acks < 5; c++) begin
            @(negedge clk);
            if (cs_n == 4'hF) gap++;
            else begin
                if (seen_low && gap > 0 && gap < min_gap) min_gap = gap;
                gap = 0;
                seen_low = 1'b1;
            end
            if (ack != 4'h0) begin
                order[acks] = sel_idx(ack);
                rxs[acks] = rx_data;
                acks++;
                if (acks == 5) req = 4'h0;
            end
        end
        check("cont_ack_count", 32'(acks), 32'd5);
        check("cont_order0", 32'(order[0]), 32'd0);
        check("cont_order1", 32'(order[1]), 32'd1);
        check("cont_order2", 32'(order[2]), 32'd2);
        check("cont_order3", 32'(order[3]), 32'd3);
        check("cont_order4", 32'(order[4]), 32'd0);
        check("cont_rx1", 32'(rxs[1]), 32'h2D);
        check("cont_rx3", 32'(rxs[3]), 32'h4B);
        check("cont_rx4", 32'(rxs[4]), 32'h1E);
        check("cont_min_gap", 32'(min_gap), 32'd2);

        // m_busy stalls START; late tx_data change and req drop are ignored
        repeat (3) @(negedge clk);
        m_busy = 1'b1;
        req = 4'b0100;
        tx_data[23:16] = 8'h77;
        rx_key = 8'h00;
        first_start = -1; n_start = 0; ack_k = -1; ack_v = 4'h0; ack_rx = 8'h00; start_tx = 8'h00;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 2) tx_data[23:16] = 8'h99;
            if (k == 5) req = 4'h0;
            if (k == 8) m_busy = 1'b0;
            if (m_start) begin
                n_start++;
                if (first_start < 0) begin first_start = k; start_tx = m_tx; end
            end
            if (ack != 4'h0 && ack_k < 0) begin ack_k = k; ack_v = ack; ack_rx = rx_data; end
        end
        check("busy_first_start", 32'(first_start), 32'd9);
        check("busy_start_pulses", 32'(n_start), 32'd1);
        check("busy_m_tx", 32'(start_tx), 32'h77);
        check("busy_ack_cycle", 32'(ack_k), 32'd13);
        check("busy_ack_val", 32'(ack_v), 32'h4);
        check("busy_rx", 32'(ack_rx), 32'h77);

        // Reset in the middle of WAIT
        master_en = 1'b0;
        req = 4'b1000;
        tx_data[31:24] = 8'hC3;
        wait_sig("rstwait_start", SEL_START, 20, cyc);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstwait_cs_n", 32'(cs_n), 32'hF);
        check("rstwait_ack", 32'(ack), 32'h0);
        rst = 1'b0;
        master_en = 1'b1;
        req = 4'b1001;
        tx_data[7:0] = 8'h5E;
        wait_sig("rstwait_ack", SEL_ACK, 50, cyc);
        check("rstwait_next_winner", 32'(ack), 32'h1);
        check("rstwait_rx", 32'(rx_data), 32'h5E);
        req = 4'h0;
        repeat (3) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
        // Master never answers: err after TIMEOUT cycles in WAIT
        master_en = 1'b0;
        req = 4'b0010;
        tx_data[15:8] = 8'h3C;
        wait_sig("to_start", SEL_START, 20, cyc);
        wait_sig("to_err", SEL_ERR, 40, cyc);
        check("to_err_latency", 32'(cyc), 32'd16);
        check("to_err_val", 32'(err), 32'h2);
        check("to_rx", 32'(rx_data), 32'h00);
        check("to_ack", 32'(ack), 32'h0);
        req = 4'h0;
        master_en = 1'b1;
        repeat (3) @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
